spdif_frame_ctrl: RTL and testbench
===================================

// Module: spdif_frame_ctrl
// PURPOSE
//  Sequencer behind the S/PDIF receiver core. Consumes per-subframe strobes (flag/enable/bfr),
//  enforces B/M/W preamble order, counts 192-frame blocks, pairs L/R subframes into stereo
//  samples on a valid/ready stream, captures channel-status bits, reports lock and errors.
// PARAMETERS
//  TIMEOUT_CYC  4096  clocks with no enable before lock is dropped and FSM returns to HUNT
//  CS_BITS      32    leading channel-status bits (left subframes, frames 0..CS_BITS-1) captured
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  flag         in   3        core preamble code: 3'b001=B, 3'b010=M, 3'b100=W, else invalid
//  enable       in   1        1-cycle strobe: flag and bfr valid this cycle
//  bfr          in   25       [23:0] audio sample (aux+audio), [24] channel-status C bit
//  out_l        out  24       left sample of current pair
//  out_r        out  24       right sample of current pair
//  out_valid    out  1        pair available; held until out_ready
//  out_ready    in   1        sink accepts pair when out_valid & out_ready
//  block_start  out  1        1-cycle pulse with the pair pushed for frame 0
//  locked       out  1        high after first full 192-frame block, low on any error/timeout
//  seq_err      out  1        1-cycle pulse on preamble-order violation
//  overrun      out  1        1-cycle pulse when a completed pair is dropped (out_valid & !out_ready)
//  cs_word      out  CS_BITS  captured channel status, bit i = C of left subframe of frame i
//  cs_valid     out  1        1-cycle pulse when cs_word updated (end of frame 191)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=HUNT; frame_cnt=0; timeout counter=0. Reset mid-block discards pair.
//  Inputs acted on only when enable=1. States:
//   HUNT  : enable&B -> latch L=bfr[23:0], frame_cnt=0, -> EXP_R. Other codes ignored (no seq_err).
//   EXP_R : enable&W -> latch R, push pair, -> EXP_L. enable&(B|M|invalid) -> seq_err, -> HUNT.
//   EXP_L : enable&M&frame_cnt in 1..191 -> latch L, -> EXP_R.
//           enable&B&frame_cnt==192 (wrap) -> frame_cnt=0, latch L, -> EXP_R.
//           any other code -> seq_err, locked=0, -> HUNT.
//  frame_cnt increments on each pushed pair (range 0..192, 192 only transiently before wrap).
//  Push: cycle after W strobe, out_l/out_r/out_valid update; latency 1 clk from W enable.
//   If out_valid=1 and out_ready=0 at push: new pair dropped, old held, overrun pulses.
//   Same-cycle out_ready and push: old pair consumed, new pair loaded, out_valid stays 1.
//  block_start asserted with out_valid rising for frame 0 pair; cleared on handshake.
//  locked: set when pair for frame 191 pushed with no error since last B; cleared on seq_err,
//   timeout, reset. Samples still streamed while unlocked once a B has been seen.
//  Timeout: counter clears on enable, increments otherwise, saturates; reaching TIMEOUT_CYC ->
//   HUNT, locked=0, no seq_err. out_valid pair retained until consumed.
// CONFIGURATION
//  SPDIF_CS_CAPTURE_EN defined: C bits of left subframes frames 0..CS_BITS-1 shifted into
//   staging reg; cs_word loaded and cs_valid pulsed when frame 191 pair pushed error-free.
//  Not defined: cs_word=0, cs_valid=0 constantly; no capture logic synthesised.
// STRUCTURE
//  spdif_pkg: flag codes (PRE_B/PRE_M/PRE_W), bfr field indices (SAMPLE_MSB, CS_BIT),
//   FRAMES_PER_BLOCK=192, FSM state enum {HUNT, EXP_R, EXP_L}.
//  One sub-module: spdif_cs_capture (staging shift reg + load/pulse), instantiated only under
//   SPDIF_CS_CAPTURE_EN. FSM, counters, output register in top.
// TESTING
//  1 Reset, then B(L=24'h123456) W(R=24'hABCDEF), out_ready=1 -> out_l=123456, out_r=ABCDEF,
//    out_valid 1 clk after W, block_start=1, locked=0.
//  2 Full block B,W,(M,W)x191 then B -> locked rises at pair 191, cs_valid pulses once,
//    second B accepted with no seq_err, frame_cnt wraps to 0.
//  3 C bits = 1 on left frames 0,2 only (CS_BITS=32, macro on) -> cs_word=32'h0000_0005;
//    macro off -> cs_word=0, cs_valid never pulses.
//  4 While locked inject M where W expected -> seq_err 1 clk, locked=0, FSM HUNT, following
//    M/W ignored until next B.
//  5 out_ready=0 for two pairs -> first pair held, second dropped with overrun pulse; out_ready=1
//    -> first pair consumed, stream resumes with third pair.
//  6 Locked, then no enable for TIMEOUT_CYC=4096 clks -> locked=0, no seq_err; rst high mid-block
//    -> all outputs 0 next clk.

Source files
------------

// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF frame sequencer: preamble codes,
// bfr field positions, block geometry and FSM state encoding.
package spdif_pkg;

  localparam logic [2:0] PRE_B = 3'b001;
  localparam logic [2:0] PRE_M = 3'b010;
  localparam logic [2:0] PRE_W = 3'b100;

  localparam int unsigned SAMPLE_W         = 24;
  localparam int unsigned SAMPLE_MSB       = SAMPLE_W - 1;
  localparam int unsigned CS_BIT           = 24;
  localparam int unsigned BFR_W            = 25;
  localparam int unsigned FRAMES_PER_BLOCK = 192;
  localparam int unsigned FCNT_W           = 8;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    EXP_R = 2'd1,
    EXP_L = 2'd2
  } state_t;

endpackage

// File: rtl/spdif_frame_ctrl_if.sv
// Subframe strobe input and stereo-pair valid/ready stream of the frame sequencer.
// master = receiver core / sink side, slave = spdif_frame_ctrl.
interface spdif_frame_ctrl_if;
  import spdif_pkg::*;

  logic [2:0]          flag;
  logic                enable;
  logic [BFR_W-1:0]    bfr;
  logic [SAMPLE_W-1:0] out_l;
  logic [SAMPLE_W-1:0] out_r;
  logic                out_valid;
  logic                out_ready;
  logic                block_start;

  modport master (
    output flag, enable, bfr, out_ready,
    input  out_l, out_r, out_valid, block_start
  );

  modport slave (
    input  flag, enable, bfr, out_ready,
    output out_l, out_r, out_valid, block_start
  );

endinterface

// File: rtl/spdif_cs_capture.sv
// Channel-status capture: shifts left-subframe C bits into a staging register
// (frame 0 ends at bit 0) and publishes it with a one-cycle cs_valid pulse.
module spdif_cs_capture #(
  parameter int unsigned CS_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_en,
  input  logic               c_bit,
  input  logic               load,
  output logic [CS_BITS-1:0] cs_word,
  output logic               cs_valid
);

  logic [CS_BITS-1:0] staging;

  always_ff @(posedge clk) begin
    if (rst) begin
      staging  <= '0;
      cs_word  <= '0;
      cs_valid <= 1'b0;
    end else begin
      cs_valid <= load;
      if (cap_en) staging <= {c_bit, staging[CS_BITS-1:1]};
      if (load)   cs_word <= staging;
    end
  end

endmodule

// File: rtl/spdif_frame_ctrl.sv
// S/PDIF frame sequencer: B/M/W order check, 192-frame block tracking, L/R pairing
// onto a valid/ready stream, lock/timeout. Channel-status capture under SPDIF_CS_CAPTURE_EN.
module spdif_frame_ctrl
  import spdif_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CS_BITS     = 32
) (
  input  logic               clk,
  input  logic               rst,
  spdif_frame_ctrl_if.slave  bus,
  output logic               locked,
  output logic               seq_err,
  output logic               overrun,
  output logic [CS_BITS-1:0] cs_word,
  output logic               cs_valid
);

  localparam int unsigned       TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(FRAMES_PER_BLOCK - 1);
  localparam logic [FCNT_W-1:0] WRAP_FRAME = FCNT_W'(FRAMES_PER_BLOCK);

  state_t              state, state_d;
  logic [FCNT_W-1:0]   frame_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [SAMPLE_W-1:0] lat_l;

  logic is_b_c, is_m_c, is_w_c;
  logic latch_l_c, zero_cnt_c, push_c, err_c;
  logic timeout_c, last_pair_c, load_c, hshk_c;

  assign is_b_c = bus.enable && (bus.flag == PRE_B);
  assign is_m_c = bus.enable && (bus.flag == PRE_M);
  assign is_w_c = bus.enable && (bus.flag == PRE_W);

  // Fires once, on the idle cycle that takes the counter to TIMEOUT_CYC.
  assign timeout_c = !bus.enable && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (timeout_c) begin
      state_d = HUNT;
    end else begin
      case (state)
        HUNT:    if (latch_l_c) state_d = EXP_R;
        EXP_R:   if (push_c) state_d = EXP_L;
                 else if (err_c) state_d = HUNT;
        EXP_L:   if (latch_l_c) state_d = EXP_R;
                 else if (err_c) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Strobe decode per state; HUNT silently ignores everything but B.
  always_comb begin
    latch_l_c  = 1'b0;
    zero_cnt_c = 1'b0;
    push_c     = 1'b0;
    err_c      = 1'b0;
    case (state)
      HUNT: begin
        if (is_b_c) begin
          latch_l_c  = 1'b1;
          zero_cnt_c = 1'b1;
        end
      end
      EXP_R: begin
        if (is_w_c)          push_c = 1'b1;
        else if (bus.enable) err_c  = 1'b1;
      end
      EXP_L: begin
        if (is_m_c && (frame_cnt != '0) && (frame_cnt <= LAST_FRAME)) begin
          latch_l_c = 1'b1;
        end else if (is_b_c && (frame_cnt == WRAP_FRAME)) begin
          latch_l_c  = 1'b1;
          zero_cnt_c = 1'b1;
        end else if (bus.enable) begin
          err_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign last_pair_c = push_c && (frame_cnt == LAST_FRAME);
  assign hshk_c      = bus.out_valid && bus.out_ready;
  assign load_c      = push_c && (!bus.out_valid || bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt       <= '0;
      tmo_cnt         <= '0;
      lat_l           <= '0;
      bus.out_l       <= '0;
      bus.out_r       <= '0;
      bus.out_valid   <= 1'b0;
      bus.block_start <= 1'b0;
      locked          <= 1'b0;
      seq_err         <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      if (bus.enable)                              tmo_cnt <= '0;
      else if (tmo_cnt != TMO_W'(TIMEOUT_CYC))     tmo_cnt <= tmo_cnt + 1'b1;

      if (latch_l_c) lat_l <= bus.bfr[SAMPLE_MSB:0];

      if (zero_cnt_c)  frame_cnt <= '0;
      else if (push_c) frame_cnt <= frame_cnt + 1'b1;

      // Output pair register: a push into a stalled slot is dropped.
      if (load_c) begin
        bus.out_l       <= lat_l;
        bus.out_r       <= bus.bfr[SAMPLE_MSB:0];
        bus.out_valid   <= 1'b1;
        bus.block_start <= (frame_cnt == '0);
      end else if (hshk_c) begin
        bus.out_valid   <= 1'b0;
        bus.block_start <= 1'b0;
      end

      overrun <= push_c && bus.out_valid && !bus.out_ready;
      seq_err <= err_c;

      if (err_c || timeout_c) locked <= 1'b0;
      else if (last_pair_c)   locked <= 1'b1;
    end
  end

`ifdef SPDIF_CS_CAPTURE_EN
  logic [FCNT_W-1:0] l_frame_c;
  logic              cs_cap_c;

  assign l_frame_c = zero_cnt_c ? '0 : frame_cnt;
  assign cs_cap_c  = latch_l_c && (32'(l_frame_c) < CS_BITS);

  spdif_cs_capture #(
    .CS_BITS (CS_BITS)
  ) u_cs_capture (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cs_cap_c),
    .c_bit    (bus.bfr[CS_BIT]),
    .load     (last_pair_c),
    .cs_word  (cs_word),
    .cs_valid (cs_valid)
  );
`else
  logic cs_unused;

  assign cs_unused = bus.bfr[CS_BIT];
  assign cs_word   = '0;
  assign cs_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_spdif_frame_ctrl.sv
// Scoreboard bench for spdif_frame_ctrl: directed subframe sequences, expected
// pairs queued at stimulus time and popped by a monitor on each handshake.
module tb_spdif_frame_ctrl;
  import spdif_pkg::*;

  localparam int unsigned CS_BITS     = 32;
  localparam int unsigned TIMEOUT_CYC = 4096;
`ifdef SPDIF_CS_CAPTURE_EN
  localparam bit CS_ON = 1'b1;
`else
  localparam bit CS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic        bs;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               locked, seq_err, overrun, cs_valid;
  logic [CS_BITS-1:0] cs_word;

  spdif_frame_ctrl_if bus ();

  spdif_frame_ctrl #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CS_BITS     (CS_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .locked   (locked),
    .seq_err  (seq_err),
    .overrun  (overrun),
    .cs_word  (cs_word),
    .cs_valid (cs_valid)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   n_seq  = 0;
  int   n_ovr  = 0;
  int   n_csv  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic logic [23:0] lval(input int i);
    return 24'hA00000 | 24'(i);
  endfunction

  function automatic logic [23:0] rval(input int i);
    return 24'hB00000 | 24'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counters and pair scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (seq_err)  n_seq++;
      if (overrun)  n_ovr++;
      if (cs_valid) n_csv++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pair_unexpected: got l=%h r=%h expected no pair", bus.out_l, bus.out_r);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pair_l", 64'(bus.out_l), 64'(mon_e.l));
          chk("pair_r", 64'(bus.out_r), 64'(mon_e.r));
          chk("pair_block_start", 64'(bus.block_start), 64'(mon_e.bs));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] f, input logic [23:0] s, input logic c);
    bus.flag   = f;
    bus.bfr    = {c, s};
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    bus.flag   = 3'b000;
  endtask

  task automatic frame(input int i, input logic c, input logic pushed);
    send(PRE_M, lval(i), c);
    if (pushed) exp_q.push_back('{l: lval(i), r: rval(i), bs: 1'b0});
    send(PRE_W, rval(i), 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"},   64'(bus.out_valid),   64'(0));
    chk({tag, "_out_l"},       64'(bus.out_l),       64'(0));
    chk({tag, "_out_r"},       64'(bus.out_r),       64'(0));
    chk({tag, "_block_start"}, 64'(bus.block_start), 64'(0));
    chk({tag, "_locked"},      64'(locked),          64'(0));
    chk({tag, "_seq_err"},     64'(seq_err),         64'(0));
    chk({tag, "_overrun"},     64'(overrun),         64'(0));
    chk({tag, "_cs_word"},     64'(cs_word),         64'(0));
    chk({tag, "_cs_valid"},    64'(cs_valid),        64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bus.flag      = 3'b000;
    bus.bfr       = '0;
    bus.enable    = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(1);

    // First pair of a block, sink always ready.
    bus.out_ready = 1'b1;
    send(PRE_B, 24'h123456, 1'b1);
    exp_q.push_back('{l: 24'h123456, r: 24'hABCDEF, bs: 1'b1});
    send(PRE_W, 24'hABCDEF, 1'b0);
    chk("t1_out_valid", 64'(bus.out_valid), 64'(1));
    chk("t1_out_l", 64'(bus.out_l), 64'(24'h123456));
    chk("t1_out_r", 64'(bus.out_r), 64'(24'hABCDEF));
    chk("t1_block_start", 64'(bus.block_start), 64'(1));
    chk("t1_locked", 64'(locked), 64'(0));

    // Rest of the block; C bit set on left of frames 0 and 2.
    for (int i = 1; i < 192; i++) begin
      if (i == 191) chk("t2_locked_before_191", 64'(locked), 64'(0));
      frame(i, (i == 2), 1'b1);
    end
    chk("t2_locked", 64'(locked), 64'(1));
    chk("t2_cs_valid", 64'(cs_valid), 64'(CS_ON));
    chk("t2_cs_word", 64'(cs_word), CS_ON ? 64'h5 : 64'h0);
    send(PRE_B, lval(0), 1'b0);
    chk("t2_wrap_seq_err", 64'(seq_err), 64'(0));
    exp_q.push_back('{l: lval(0), r: rval(0), bs: 1'b1});
    send(PRE_W, rval(0), 1'b0);
    chk("t2_wrap_block_start", 64'(bus.block_start), 64'(1));
    chk("t2_wrap_locked", 64'(locked), 64'(1));
    chk("t2_seq_err_count", 64'(n_seq), 64'(0));
    chk("t2_cs_valid_count", 64'(n_csv), CS_ON ? 64'd1 : 64'd0);

    // M where W expected while locked.
    send(PRE_M, lval(1), 1'b0);
    send(PRE_M, lval(9), 1'b0);
    chk("t4_seq_err", 64'(seq_err), 64'(1));
    chk("t4_locked", 64'(locked), 64'(0));
    send(PRE_W, rval(9), 1'b0);
    send(PRE_M, lval(10), 1'b0);
    send(PRE_W, rval(10), 1'b0);
    idle(2);
    chk("t4_seq_err_count", 64'(n_seq), 64'(1));
    chk("t4_no_output", 64'(bus.out_valid), 64'(0));

    // Stalled sink: first pair held, second dropped.
    bus.out_ready = 1'b0;
    send(PRE_B, lval(0), 1'b0);
    exp_q.push_back('{l: lval(0), r: rval(0), bs: 1'b1});
    send(PRE_W, rval(0), 1'b0);
    send(PRE_M, lval(1), 1'b0);
    send(PRE_W, rval(1), 1'b0);
    chk("t5_overrun", 64'(overrun), 64'(1));
    chk("t5_held_valid", 64'(bus.out_valid), 64'(1));
    chk("t5_held_r", 64'(bus.out_r), 64'(rval(0)));
    idle(2);
    chk("t5_overrun_count", 64'(n_ovr), 64'(1));
    bus.out_ready = 1'b1;
    idle(2);
    chk("t5_drained", 64'(bus.out_valid), 64'(0));
    frame(2, 1'b0, 1'b1);

    // Complete the block to relock, then go silent.
    for (int i = 3; i < 192; i++) frame(i, 1'b0, 1'b1);
    chk("t6_locked", 64'(locked), 64'(1));
    chk("t6_cs_word", 64'(cs_word), 64'(0));
    idle(2);
    chk("t6_cs_valid_count", 64'(n_csv), CS_ON ? 64'd2 : 64'd0);
    idle(4000);
    chk("t6_locked_pre_timeout", 64'(locked), 64'(1));
    idle(200);
    chk("t6_locked_timeout", 64'(locked), 64'(0));
    chk("t6_seq_err_count", 64'(n_seq), 64'(1));

    // Fresh B after timeout, then reset with a pair pending.
    send(PRE_B, lval(5), 1'b0);
    exp_q.push_back('{l: lval(5), r: rval(5), bs: 1'b1});
    send(PRE_W, rval(5), 1'b0);
    idle(1);
    send(PRE_M, lval(6), 1'b0);
    bus.out_ready = 1'b0;
    exp_q.push_back('{l: lval(6), r: rval(6), bs: 1'b0});
    send(PRE_W, rval(6), 1'b0);
    chk("t6_pending_valid", 64'(bus.out_valid), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    void'(exp_q.pop_back());
    rst = 1'b0;
    idle(2);
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
